retro_bram_arbiter: RTL

RETRO_BRAM_ARBITER -- requirements
Module: retro_bram_arbiter

---
 rtl/retro_bram_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/retro_bram_arbiter.sv
// retro_bram_arbiter
//   Two-requester arbiter in front of a single-port BRAM with registered read
//   data. At most one access is granted per cycle. Ties are resolved
//   round-robin unless the previous owner holds a lock. A lock is broken after
//   MaxLock consecutive grants while the other side waits.
//
// Ports
//   Clk, Reset_n              clock, asynchronous active-low reset
//   ReqX_Access/Lock/Write    request, keep-ownership hint, byte write strobes
//   ReqX_Address/Din          access address and write data
//   ReqX_Ready                grant (combinational, same cycle)
//   ReqX_DataReady/Dout       read data qualifier and data (one cycle after grant)
//   Mem_*                     single-port BRAM side
//
// state     | meaning
// ----------+-------------------------------------------
// ST_IDLE   | no lock; ties go to the requester not granted last
// ST_LOCK_A | A holds priority while it keeps requesting
// ST_LOCK_B | B holds priority while it keeps requesting
module retro_bram_arbiter #(
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 1,
    parameter int MaxLock         = 4
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         ReqA_Access,
    input  logic                         ReqA_Lock,
    input  logic [DataBusWidth-1:0]      ReqA_Write,
    input  logic [AddressBusWidth-1:0]   ReqA_Address,
    input  logic [8*DataBusWidth-1:0]    ReqA_Din,
    output logic                         ReqA_Ready,
    output logic                         ReqA_DataReady,
    output logic [8*DataBusWidth-1:0]    ReqA_Dout,
    input  logic                         ReqB_Access,
    input  logic                         ReqB_Lock,
    input  logic [DataBusWidth-1:0]      ReqB_Write,
    input  logic [AddressBusWidth-1:0]   ReqB_Address,
    input  logic [8*DataBusWidth-1:0]    ReqB_Din,
    output logic                         ReqB_Ready,
    output logic                         ReqB_DataReady,
    output logic [8*DataBusWidth-1:0]    ReqB_Dout,
    output logic                         Mem_Access,
    output logic [DataBusWidth-1:0]      Mem_Write,
    output logic [AddressBusWidth-1:0]   Mem_Address,
    output logic [8*DataBusWidth-1:0]    Mem_Din,
    input  logic [8*DataBusWidth-1:0]    Mem_Dout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK_A = 2'd1;
    localparam logic [1:0] ST_LOCK_B = 2'd2;
    localparam logic [7:0] MAX_LOCK  = 8'(MaxLock);

    logic [1:0] state_q, state_d;
    logic       last_b_q, last_b_d;     // 1: B was granted most recently
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       pend_a_q, pend_a_d;
    logic       pend_b_q, pend_b_d;
    logic       grant_a, grant_b;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (ReqA_Access && !ReqB_Access) begin
            grant_a = 1'b1;
        end else if (!ReqA_Access && ReqB_Access) begin
            grant_b = 1'b1;
        end else if (ReqA_Access && ReqB_Access) begin
            case (state_q)
                ST_LOCK_A: begin
                    if (lock_cnt_q == MAX_LOCK) grant_b = 1'b1;
                    else                        grant_a = 1'b1;
                end
                ST_LOCK_B: begin
                    if (lock_cnt_q == MAX_LOCK) grant_a = 1'b1;
                    else                        grant_b = 1'b1;
                end
                default: begin
                    if (last_b_q) grant_a = 1'b1;
                    else          grant_b = 1'b1;
                end
            endcase
        end
        // Outputs must stay quiet while reset is held, even with requests up.
        if (!Reset_n) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        lock_cnt_d = lock_cnt_q;
        pend_a_d   = grant_a && (ReqA_Write == '0);
        pend_b_d   = grant_b && (ReqB_Write == '0);

        if (grant_a)      last_b_d = 1'b0;
        else if (grant_b) last_b_d = 1'b1;

        // Count only repeated grants that made the other side wait.
        if (grant_a) begin
            if (last_b_q)                                   lock_cnt_d = 8'd0;
            else if (ReqB_Access && lock_cnt_q != 8'hFF)    lock_cnt_d = lock_cnt_q + 8'd1;
        end else if (grant_b) begin
            if (!last_b_q)                                  lock_cnt_d = 8'd0;
            else if (ReqA_Access && lock_cnt_q != 8'hFF)    lock_cnt_d = lock_cnt_q + 8'd1;
        end else begin
            lock_cnt_d = 8'd0;
        end

        case (state_q)
            ST_LOCK_A: begin
                if (!ReqA_Access)  state_d = ST_IDLE;
                else if (grant_a)  state_d = ReqA_Lock ? ST_LOCK_A : ST_IDLE;
                else               state_d = ReqB_Lock ? ST_LOCK_B : ST_IDLE;
            end
            ST_LOCK_B: begin
                if (!ReqB_Access)  state_d = ST_IDLE;
                else if (grant_b)  state_d = ReqB_Lock ? ST_LOCK_B : ST_IDLE;
                else               state_d = ReqA_Lock ? ST_LOCK_A : ST_IDLE;
            end
            default: begin
                if (grant_a && ReqA_Lock)      state_d = ST_LOCK_A;
                else if (grant_b && ReqB_Lock) state_d = ST_LOCK_B;
                else                           state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            last_b_q   <= 1'b1;
            lock_cnt_q <= 8'd0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            lock_cnt_q <= lock_cnt_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
        end
    end

    assign ReqA_Ready     = grant_a;
    assign ReqB_Ready     = grant_b;
    assign ReqA_DataReady = pend_a_q;
    assign ReqB_DataReady = pend_b_q;
    assign ReqA_Dout      = Mem_Dout;
    assign ReqB_Dout      = Mem_Dout;

    assign Mem_Access  = grant_a | grant_b;
    assign Mem_Write   = grant_a ? ReqA_Write : (grant_b ? ReqB_Write : '0);
    assign Mem_Address = grant_b ? ReqB_Address : ReqA_Address;
    assign Mem_Din     = grant_b ? ReqB_Din : ReqA_Din;

endmodule
